// File: rtl/segre_pkg.sv
// Shared types and constants for the segre memory subsystem.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package segre_pkg;

    localparam int DCACHE_LANE_SIZE    = 128;
    localparam int MM_ARB_STARVE_LIMIT = 4;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } memop_data_type_e;

    typedef enum logic [2:0] {
        IDLE,
        RD_IC,
        RD_DC,
        WR_DC,
        DONE
    } mm_arb_state_e;

    typedef enum logic [1:0] {
        SRC_IC,
        SRC_DC_RD,
        SRC_DC_WR
    } mm_req_src_e;

endpackage

// File: rtl/segre_mm_arb_prio.sv
// Priority picker for the main-memory arbiter: dc_wr > dc_rd > ic_rd, I side forced when starved.
// Latency: purely combinational.
// Backpressure: none; the caller only samples the pick while idle.
// Ports: ic/dc_rd/dc_wr request levels and a starved flag in; grant valid and source out.
module segre_mm_arb_prio
    import segre_pkg::*;
(
    input  logic        ic_req_i,
    input  logic        dc_rd_req_i,
    input  logic        dc_wr_req_i,
    input  logic        ic_starved_i,
    output logic        grant_vld_o,
    output mm_req_src_e grant_src_o
);

    always_comb begin
        grant_vld_o = ic_req_i | dc_rd_req_i | dc_wr_req_i;
        grant_src_o = SRC_IC;
        if (ic_req_i && ic_starved_i) begin
            grant_src_o = SRC_IC;
        end else if (dc_wr_req_i) begin
            // Write ahead of read so a fill of the same line sees the stored word.
            grant_src_o = SRC_DC_WR;
        end else if (dc_rd_req_i) begin
            grant_src_o = SRC_DC_RD;
        end
    end

endmodule

// File: rtl/segre_mm_arbiter.sv
// Arbitrates the single main-memory port between I-fill, D-fill and D-write requesters.
// Latency: grant -> mm request 1 cycle; mm_data_rdy_i -> done pulse 1 cycle; min 4 cycles per transaction.
// Backpressure: requests are levels held until their done pulse; mm_rd_o/mm_wr_o held until mm_data_rdy_i.
// Ports: clk_i/rsn_i; ic_rd_*, dc_rd_*, dc_wr_* requester side with *_done_o pulses, rd_data_o and busy_o;
//        mm_* memory side (level request, shared completion strobe mm_data_rdy_i).
module segre_mm_arbiter
    import segre_pkg::*;
#(
    parameter int ADDR_SIZE    = 32,
    parameter int WORD_SIZE    = 32,
    parameter int LANE_SIZE    = DCACHE_LANE_SIZE,
    parameter int STARVE_LIMIT = MM_ARB_STARVE_LIMIT
) (
    input  logic                 clk_i,
    input  logic                 rsn_i,

    input  logic                 ic_rd_req_i,
    input  logic [ADDR_SIZE-1:0] ic_rd_addr_i,
    input  logic                 dc_rd_req_i,
    input  logic [ADDR_SIZE-1:0] dc_rd_addr_i,
    input  logic                 dc_wr_req_i,
    input  logic [ADDR_SIZE-1:0] dc_wr_addr_i,
    input  logic [WORD_SIZE-1:0] dc_wr_data_i,
    input  memop_data_type_e     dc_wr_type_i,

    output logic                 ic_rd_done_o,
    output logic                 dc_rd_done_o,
    output logic                 dc_wr_done_o,
    output logic [LANE_SIZE-1:0] rd_data_o,
    output logic                 busy_o,

    input  logic                 mm_data_rdy_i,
    input  logic [LANE_SIZE-1:0] mm_rd_data_i,
    output logic                 mm_rd_o,
    output logic                 mm_wr_o,
    output logic [ADDR_SIZE-1:0] mm_addr_o,
    output logic [ADDR_SIZE-1:0] mm_wr_addr_o,
    output logic [WORD_SIZE-1:0] mm_wr_data_o,
    output memop_data_type_e     mm_wr_data_type_o
);

    localparam int               CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    mm_arb_state_e    state_q, state_d;
    mm_req_src_e      src_q, src_d;
    logic [ADDR_SIZE-1:0] addr_q, addr_d;
    logic [WORD_SIZE-1:0] wr_data_q, wr_data_d;
    memop_data_type_e     wr_type_q, wr_type_d;
    logic [LANE_SIZE-1:0] rd_data_q, rd_data_d;
    logic [CNT_W-1:0]     starve_cnt_q, starve_cnt_d;

    logic        grant_vld;
    mm_req_src_e grant_src;

    segre_mm_arb_prio u_prio (
        .ic_req_i     (ic_rd_req_i),
        .dc_rd_req_i  (dc_rd_req_i),
        .dc_wr_req_i  (dc_wr_req_i),
        .ic_starved_i (starve_cnt_q == CNT_MAX),
        .grant_vld_o  (grant_vld),
        .grant_src_o  (grant_src)
    );

    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        addr_d       = addr_q;
        wr_data_d    = wr_data_q;
        wr_type_d    = wr_type_q;
        rd_data_d    = rd_data_q;
        starve_cnt_d = starve_cnt_q;

        case (state_q)
            IDLE: begin
                // Nobody waiting on the I side means nobody is being starved.
                if (!ic_rd_req_i) begin
                    starve_cnt_d = '0;
                end
                if (grant_vld) begin
                    src_d = grant_src;
                    case (grant_src)
                        SRC_IC: begin
                            state_d      = RD_IC;
                            addr_d       = ic_rd_addr_i;
                            starve_cnt_d = '0;
                        end
                        SRC_DC_RD: begin
                            state_d = RD_DC;
                            addr_d  = dc_rd_addr_i;
                        end
                        default: begin
                            state_d   = WR_DC;
                            addr_d    = dc_wr_addr_i;
                            wr_data_d = dc_wr_data_i;
                            wr_type_d = dc_wr_type_i;
                        end
                    endcase
                    if (grant_src != SRC_IC && ic_rd_req_i && starve_cnt_q != CNT_MAX) begin
                        starve_cnt_d = starve_cnt_q + CNT_W'(1);
                    end
                end
            end
            RD_IC, RD_DC: begin
                if (mm_data_rdy_i) begin
                    rd_data_d = mm_rd_data_i;
                    state_d   = DONE;
                end
            end
            WR_DC: begin
                if (mm_data_rdy_i) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rsn_i) begin
            state_q      <= IDLE;
            src_q        <= SRC_IC;
            addr_q       <= '0;
            wr_data_q    <= '0;
            wr_type_q    <= BYTE;
            rd_data_q    <= '0;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            src_q        <= src_d;
            addr_q       <= addr_d;
            wr_data_q    <= wr_data_d;
            wr_type_q    <= wr_type_d;
            rd_data_q    <= rd_data_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // All outputs decode registered state only, so they are glitch-free and input-independent.
    assign busy_o            = (state_q != IDLE);
    assign mm_rd_o           = (state_q == RD_IC) || (state_q == RD_DC);
    assign mm_wr_o           = (state_q == WR_DC);
    assign mm_addr_o         = addr_q;
    assign mm_wr_addr_o      = addr_q;
    assign mm_wr_data_o      = wr_data_q;
    assign mm_wr_data_type_o = wr_type_q;
    assign rd_data_o         = rd_data_q;
    assign ic_rd_done_o      = (state_q == DONE) && (src_q == SRC_IC);
    assign dc_rd_done_o      = (state_q == DONE) && (src_q == SRC_DC_RD);
    assign dc_wr_done_o      = (state_q == DONE) && (src_q == SRC_DC_WR);

endmodule

// File: tb/tb_segre_mm_arbiter.sv
module tb_segre_mm_arbiter;
    import segre_pkg::*;

    localparam int LIMIT = MM_ARB_STARVE_LIMIT;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rsn;
    logic             ic_req, rd_req, wr_req;
    logic [31:0]      ic_addr, rd_addr, wr_addr, wr_data;
    memop_data_type_e wr_type;
    logic             mm_rdy;
    logic [127:0]     mm_lane;

    logic             ic_done, dc_rd_done, dc_wr_done, busy, mm_rd, mm_wr;
    logic [127:0]     rd_data;
    logic [31:0]      mm_addr, mm_wr_addr, mm_wr_data;
    memop_data_type_e mm_wr_type;

    segre_mm_arbiter dut (
        .clk_i             (clk),
        .rsn_i             (rsn),
        .ic_rd_req_i       (ic_req),
        .ic_rd_addr_i      (ic_addr),
        .dc_rd_req_i       (rd_req),
        .dc_rd_addr_i      (rd_addr),
        .dc_wr_req_i       (wr_req),
        .dc_wr_addr_i      (wr_addr),
        .dc_wr_data_i      (wr_data),
        .dc_wr_type_i      (wr_type),
        .ic_rd_done_o      (ic_done),
        .dc_rd_done_o      (dc_rd_done),
        .dc_wr_done_o      (dc_wr_done),
        .rd_data_o         (rd_data),
        .busy_o            (busy),
        .mm_data_rdy_i     (mm_rdy),
        .mm_rd_data_i      (mm_lane),
        .mm_rd_o           (mm_rd),
        .mm_wr_o           (mm_wr),
        .mm_addr_o         (mm_addr),
        .mm_wr_addr_o      (mm_wr_addr),
        .mm_wr_data_o      (mm_wr_data),
        .mm_wr_data_type_o (mm_wr_type)
    );

    // Transaction-level reference: which requester owns the port, what it asked for,
    // and which lane the requester must finally see.
    typedef enum int {P_IDLE, P_MM, P_DONE} phase_e;
    typedef struct {
        mm_req_src_e      src;
        logic [31:0]      addr;
        logic [31:0]      data;
        memop_data_type_e typ;
    } req_t;
    typedef struct {
        mm_req_src_e  src;
        logic [127:0] lane;
    } done_t;

    phase_e       m_phase;
    mm_req_src_e  m_src;
    int           m_cnt;
    logic [127:0] m_rd_data;
    logic         m_new_grant;
    int           mem_wait;
    int           mode;
    req_t         exp_req_q[$];
    done_t        exp_done_q[$];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] src_vec(input mm_req_src_e s);
        case (s)
            SRC_IC:    return 3'b100;
            SRC_DC_RD: return 3'b010;
            default:   return 3'b001;
        endcase
    endfunction

    function automatic logic [127:0] rand_lane();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Apply the effect of the clock edge that just happened, using the inputs held across it.
    task automatic model_edge();
        mm_req_src_e s;
        req_t        r;
        done_t       d;
        m_new_grant = 1'b0;
        if (!rsn) begin
            m_phase   = P_IDLE;
            m_cnt     = 0;
            m_rd_data = '0;
            exp_req_q.delete();
            exp_done_q.delete();
        end else if (m_phase == P_IDLE) begin
            if (ic_req || rd_req || wr_req) begin
                if (ic_req && m_cnt == LIMIT) s = SRC_IC;
                else if (wr_req)              s = SRC_DC_WR;
                else if (rd_req)              s = SRC_DC_RD;
                else                          s = SRC_IC;
                if (!ic_req || s == SRC_IC) m_cnt = 0;
                else if (m_cnt < LIMIT)     m_cnt = m_cnt + 1;
                r.src  = s;
                r.addr = (s == SRC_IC) ? ic_addr : (s == SRC_DC_WR) ? wr_addr : rd_addr;
                r.data = wr_data;
                r.typ  = wr_type;
                exp_req_q.push_back(r);
                m_src       = s;
                m_phase     = P_MM;
                m_new_grant = 1'b1;
                if (mode == 2 && $urandom_range(0, 1) == 0) mem_wait = 19;
                else                                        mem_wait = $urandom_range(0, 3);
            end else begin
                m_cnt = 0;
            end
        end else if (m_phase == P_MM) begin
            if (mm_rdy) begin
                if (m_src != SRC_DC_WR) m_rd_data = mm_lane;
                d.src  = m_src;
                d.lane = m_rd_data;
                exp_done_q.push_back(d);
                m_phase = P_DONE;
            end
        end else begin
            m_phase = P_IDLE;
        end
    endtask

    // Requesters and memory for the next cycle.
    task automatic drive_next();
        logic drop_ic, drop_rd, drop_wr;
        int   p;
        drop_ic = 1'b0;
        drop_rd = 1'b0;
        drop_wr = 1'b0;
        rsn     = 1'b1;
        mm_rdy  = 1'b0;
        if (m_phase == P_MM) begin
            if (mem_wait == 0) begin
                mm_rdy  = 1'b1;
                mm_lane = rand_lane();
            end else begin
                mem_wait--;
            end
            if (mode == 0 && $urandom_range(0, 39) == 0) rsn = 1'b0;
        end else if (m_phase == P_IDLE && $urandom_range(0, 5) == 0) begin
            mm_rdy  = 1'b1;
            mm_lane = rand_lane();
        end

        if (m_phase == P_DONE) begin
            case (m_src)
                SRC_IC:    begin ic_req = 1'b0; drop_ic = 1'b1; end
                SRC_DC_RD: begin rd_req = 1'b0; drop_rd = 1'b1; end
                default:   begin wr_req = 1'b0; drop_wr = 1'b1; end
            endcase
        end

        // The arbiter must work from its captured copy, so disturb the winner's inputs.
        if (m_new_grant) begin
            case (m_src)
                SRC_IC:    ic_addr = $urandom;
                SRC_DC_RD: rd_addr = $urandom;
                default: begin
                    wr_addr = $urandom;
                    wr_data = $urandom;
                    wr_type = memop_data_type_e'($urandom_range(0, 2));
                end
            endcase
        end

        p = (mode == 0) ? 4 : (mode == 2) ? 3 : 0;
        if (!ic_req && !drop_ic && (mode == 1 || (p != 0 && $urandom_range(1, p) == 1))) begin
            ic_req  = 1'b1;
            ic_addr = $urandom;
        end
        if (!rd_req && !drop_rd && (mode == 1 || (p != 0 && $urandom_range(1, p) == 1))) begin
            rd_req = 1'b1;
            // Often hit the same line as a pending write.
            rd_addr = ($urandom_range(0, 1) == 0) ? wr_addr : $urandom;
        end
        if (!wr_req && !drop_wr && mode != 1 && p != 0 && $urandom_range(1, p) == 1) begin
            wr_req  = 1'b1;
            wr_addr = $urandom;
            wr_data = $urandom;
            wr_type = memop_data_type_e'($urandom_range(0, 2));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
        drive_next();
    endtask

    // Monitor: sampled on the falling edge, well away from the active edge.
    logic        mon_prev_req = 1'b0;
    logic [31:0] mon_addr;
    always @(negedge clk) begin
        req_t  r;
        done_t d;
        chk("busy", 128'(busy), 128'(m_phase != P_IDLE));
        chk("mm_rd_lvl", 128'(mm_rd), 128'(m_phase == P_MM && m_src != SRC_DC_WR));
        chk("mm_wr_lvl", 128'(mm_wr), 128'(m_phase == P_MM && m_src == SRC_DC_WR));
        chk("done_vec", 128'({ic_done, dc_rd_done, dc_wr_done}),
            128'((m_phase == P_DONE) ? src_vec(m_src) : 3'b000));
        chk("rd_data", rd_data, m_rd_data);

        if ((mm_rd || mm_wr) && !mon_prev_req) begin
            if (exp_req_q.size() == 0) begin
                chk("unexpected_mm_req", 128'(1), 128'(0));
            end else begin
                r = exp_req_q.pop_front();
                chk("req_kind", 128'({mm_rd, mm_wr}), 128'((r.src == SRC_DC_WR) ? 2'b01 : 2'b10));
                if (r.src == SRC_DC_WR) begin
                    chk("mm_wr_addr", 128'(mm_wr_addr), 128'(r.addr));
                    chk("mm_wr_data", 128'(mm_wr_data), 128'(r.data));
                    chk("mm_wr_type", 128'(mm_wr_type), 128'(r.typ));
                    mon_addr = mm_wr_addr;
                end else begin
                    chk("mm_addr", 128'(mm_addr), 128'(r.addr));
                    mon_addr = mm_addr;
                end
                mon_addr = r.addr;
            end
        end else if (mm_rd) begin
            chk("mm_addr_stable", 128'(mm_addr), 128'(mon_addr));
        end else if (mm_wr) begin
            chk("mm_wr_addr_stable", 128'(mm_wr_addr), 128'(mon_addr));
        end
        mon_prev_req = mm_rd || mm_wr;

        if (ic_done || dc_rd_done || dc_wr_done) begin
            if (exp_done_q.size() == 0) begin
                chk("unexpected_done", 128'({ic_done, dc_rd_done, dc_wr_done}), 128'(0));
            end else begin
                d = exp_done_q.pop_front();
                chk("done_owner", 128'({ic_done, dc_rd_done, dc_wr_done}), 128'(src_vec(d.src)));
                if (d.src != SRC_DC_WR) chk("done_lane", rd_data, d.lane);
            end
        end
    end

    initial begin
        rsn         = 1'b0;
        ic_req      = 1'b1;
        rd_req      = 1'b1;
        wr_req      = 1'b1;
        ic_addr     = 32'h0000_0100;
        rd_addr     = 32'h0000_0200;
        wr_addr     = 32'h0000_0200;
        wr_data     = 32'hCAFE_BABE;
        wr_type     = WORD;
        mm_rdy      = 1'b0;
        mm_lane     = '0;
        m_phase     = P_IDLE;
        m_src       = SRC_IC;
        m_cnt       = 0;
        m_rd_data   = '0;
        m_new_grant = 1'b0;
        mem_wait    = 0;
        mode        = 0;

        // Reset held with every request raised; the write must win once released.
        repeat (3) begin
            @(posedge clk);
            #1;
            model_edge();
        end
        rsn = 1'b1;

        mode = 0;
        for (int i = 0; i < 1500; i++) step();
        mode = 1;
        for (int i = 0; i < 250; i++) step();
        mode = 2;
        for (int i = 0; i < 400; i++) step();
        mode = 3;
        for (int i = 0; i < 120; i++) step();

        @(negedge clk);
        #1;
        chk("req_q_drained", 128'(exp_req_q.size()), 128'(0));
        chk("done_q_drained", 128'(exp_done_q.size()), 128'(0));
        chk("idle_at_end", 128'(busy), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/segre_mm_arbiter.md
Name: segre_mm_arbiter

Overview:
Arbitrates the single main-memory port between three requesters: instruction-cache line fill, data-cache line fill and data-cache word write.
- Sits between the cache miss logic and the external mm_* interface.
- Runs one transaction at a time through a small FSM.
- Uses fixed priority, with a starvation counter that guarantees instruction fetch progress.
- Registers returned lane data and signals a one-cycle done pulse to the owning requester.

Parameters:
- ADDR_SIZE, 32, byte address width.
- WORD_SIZE, 32, store data width.
- LANE_SIZE, 128, cache line width in bits; must equal DCACHE_LANE_SIZE.
- STARVE_LIMIT, 4, consecutive D-side grants allowed while an I-side request waits.

Ports:
- clk_i  in  1  clock
- rsn_i  in  1  synchronous active-low reset
- ic_rd_req_i  in  1  I-cache fill request; level, held until ic_rd_done_o
- ic_rd_addr_i  in  ADDR_SIZE  I-cache fill address
- dc_rd_req_i  in  1  D-cache fill request; level
- dc_rd_addr_i  in  ADDR_SIZE  D-cache fill address
- dc_wr_req_i  in  1  D-cache write request; level
- dc_wr_addr_i  in  ADDR_SIZE  write address
- dc_wr_data_i  in  WORD_SIZE  write data
- dc_wr_type_i  in  memop_data_type_e  BYTE/HALF/WORD
- ic_rd_done_o  out  1  one-cycle pulse: I fill data valid
- dc_rd_done_o  out  1  one-cycle pulse: D fill data valid
- dc_wr_done_o  out  1  one-cycle pulse: write accepted by memory
- rd_data_o  out  LANE_SIZE  registered lane; valid in the done-pulse cycle
- busy_o  out  1  FSM not IDLE
- mm_data_rdy_i  in  1  memory completion, for both read and write
- mm_rd_data_i  in  LANE_SIZE  memory read lane
- mm_rd_o  out  1  read request; level, held until mm_data_rdy_i
- mm_wr_o  out  1  write request; level, held until mm_data_rdy_i
- mm_addr_o  out  ADDR_SIZE  read address
- mm_wr_addr_o  out  ADDR_SIZE  write address
- mm_wr_data_o  out  WORD_SIZE  write data
- mm_wr_data_type_o  out  memop_data_type_e  write size

Behaviour:
- One clock (clk_i); reset is synchronous and active-low (rsn_i).
- Reset values:
  - FSM goes to IDLE; starve counter is 0.
  - All mm_*, done and busy outputs are 0; rd_data_o is 0.
  - Reset mid-transaction abandons it with no done pulse.
  - Requesters must re-request after reset; a late mm_data_rdy_i arriving in IDLE is ignored.
- FSM states: IDLE, RD_IC, RD_DC, WR_DC, DONE.
- Arbitration happens in IDLE only, once per cycle:
  - Priority is dc_wr > dc_rd > ic_rd.
  - Exception: if ic_rd_req_i is set and starve_cnt == STARVE_LIMIT, the I side wins.
- Grant registers the address, data and type. The next cycle enters the RD_*/WR_DC state and asserts mm_rd_o or mm_wr_o with the registered address.
- Request-to-mm latency is 1 cycle.
- In RD_*/WR_DC, the request stays asserted until the cycle mm_data_rdy_i = 1. In that cycle:
  - For reads, mm_rd_data_i is captured into rd_data_o.
  - mm_rd_o/mm_wr_o deassert next cycle.
  - The FSM moves to DONE.
- DONE lasts one cycle:
  - Pulses the matching done output.
  - rd_data_o holds the captured lane (unchanged after DONE until the next read completes).
  - Returns to IDLE.
  - Requesters drop req in the done cycle; a still-high req in IDLE is treated as a new request.
- Minimum transaction is therefore 4 cycles (grant, request, rdy, done) when memory answers in 1 cycle. Back-to-back grants have one IDLE cycle between them.
- Starve counter:
  - Increments on each D-side grant while ic_rd_req_i = 1, saturating at STARVE_LIMIT.
  - Clears on an I-side grant, or whenever ic_rd_req_i = 0 in IDLE.
- Simultaneous dc_rd_req_i and dc_wr_req_i to the same line: the write is granted first, so the fill observes the stored data.
- Request inputs changing during a non-IDLE state are ignored; registered copies are used.
- busy_o = (state != IDLE).

Decomposition:
- segre_pkg gains:
  - mm_arb_state_e (IDLE, RD_IC, RD_DC, WR_DC, DONE);
  - mm_req_src_e (SRC_IC, SRC_DC_RD, SRC_DC_WR);
  - constant MM_ARB_STARVE_LIMIT.
  - memop_data_type_e is reused from segre_pkg.
- One natural sub-module, segre_mm_arb_prio: a combinational priority/starvation picker that outputs mm_req_src_e plus a valid bit. The FSM, registers and counter stay in the top.

Test Plan:
1. Reset hold: rsn_i = 0 for 3 cycles with all reqs high -> all outputs 0, busy_o = 0; after release, dc_wr is granted first.
2. Single I fill: ic_rd_req_i with addr 0x0000_0100, memory rdy 3 cycles after mm_rd_o, lane 0xDEADBEEF_0123... -> mm_addr_o = 0x100; ic_rd_done_o pulses once; rd_data_o equals the lane; total 6 cycles.
3. Same-cycle dc_wr (addr 0x200, data 0xCAFEBABE, WORD) and dc_rd (0x200) -> write transaction first with mm_wr_data_o = 0xCAFEBABE and mm_wr_data_type_o = WORD; then the read; dc_wr_done_o precedes dc_rd_done_o.
4. Starvation: ic_rd_req_i held while dc_rd_req_i is re-raised continuously -> exactly 4 D grants, then the I grant; the counter returns to 0.
5. Reset mid-read: rsn_i low in the RD_DC cycle before rdy -> no done pulse, mm_rd_o = 0 next cycle; a stray mm_data_rdy_i afterwards causes no pulse.
6. Slow memory: rdy arrives 20 cycles after the request -> mm_rd_o stays high for all 20 cycles with a stable address; other requests arriving meanwhile are not granted until DONE.
